// File: rtl/map_columns_scan_pkg.sv
// Shared defaults and FSM state encoding for the column/row mapping blocks
// (map_columns_scan, mapTopandBottom, draw).
package map_pkg;

  localparam int X_W_DEF       = 8;
  localparam int Y_W_DEF       = 7;
  localparam int X_RES_DEF     = 160;
  localparam int ADDR_W_DEF    = 15;
  localparam int COL_W_DEF     = 3;
  localparam int THRESHOLD_DEF = 0;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_R_ISSUE  = 4'd2,
    ST_R_WAIT   = 4'd3,
    ST_R_CHECK  = 4'd4,
    ST_L_ISSUE  = 4'd5,
    ST_L_WAIT   = 4'd6,
    ST_L_CHECK  = 4'd7,
    ST_NEXT_ROW = 4'd8,
    ST_FINISH   = 4'd9
  } scan_state_e;

endpackage

// File: rtl/map_columns_scan_pix_addr_calc.sv
// Row-major frame-buffer address: addr = y*X_RES + x (purely combinational).
import map_pkg::*;

module pix_addr_calc #(
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF,
  parameter int X_RES  = X_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  // linear address of pixel (x, y)
  always_comb begin
    addr = ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);
  end

endmodule

// File: rtl/map_columns_scan.sv
// Finds left/right extents of a bright shape over a row band, scanning outward from midPix.
// Optional abort input enabled by defining MAP_COLUMNS_SCAN_ABORT_EN.
import map_pkg::*;

module map_columns_scan #(
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int X_RES     = X_RES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int COL_W     = COL_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
`ifdef MAP_COLUMNS_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic [Y_W-1:0]    mostTop,
  input  logic [Y_W-1:0]    mostBottom,
  input  logic [X_W-1:0]    midPix,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COL_W-1:0]  mem_q,
  output logic              busy,
  output logic              done,
  output logic [X_W-1:0]    mostLeft,
  output logic [X_W-1:0]    mostRight,
  output logic              bad_range
);

  localparam logic [X_W:0]   XRES_EXT = (X_W+1)'(X_RES);
  localparam logic [X_W-1:0] XMAX     = X_W'(X_RES - 1);
  localparam logic [X_W-1:0] X_ONE    = X_W'(1);
  localparam logic [X_W-1:0] X_ZERO   = X_W'(0);
  localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);
  localparam logic [1:0]     LAT_M1   = 2'(RD_LAT - 1);

  scan_state_e       state_q, state_d;
  logic [X_W-1:0]    x_q, x_d, mid_q, mid_d, left_q, left_d, right_q, right_d;
  logic [Y_W-1:0]    y_q, y_d, top_q, top_d, bot_q, bot_d;
  logic [1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, addr_s;
  logic              busy_q, busy_d, done_q, done_d, bad_q, bad_d;
  logic              issue_s, dark_s, bad_s;

  pix_addr_calc #(.X_W(X_W), .Y_W(Y_W), .X_RES(X_RES), .ADDR_W(ADDR_W)) u_addr (
    .x    (x_d),
    .y    (y_q),
    .addr (addr_s)
  );

  // next-state and datapath update
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    top_d      = top_q;
    bot_d      = bot_q;
    mid_d      = mid_q;
    wait_d     = wait_q;
    left_d     = left_q;
    right_d    = right_q;
    bad_d      = bad_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue_s    = 1'b0;
    dark_s     = (mem_q <= COL_W'(THRESHOLD));
    bad_s      = (top_q > bot_q) || ({1'b0, mid_q} >= XRES_EXT);
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          top_d   = mostTop;
          bot_d   = mostBottom;
          mid_d   = midPix;
          busy_d  = 1'b1;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        y_d   = top_q;
        bad_d = bad_s;
        if ({1'b0, mid_q} >= XRES_EXT) begin
          left_d  = XMAX;
          right_d = XMAX;
        end else begin
          left_d  = mid_q;
          right_d = mid_q;
        end
        state_d = bad_s ? ST_FINISH : ST_R_ISSUE;
      end
      ST_R_ISSUE: begin
        if (mid_q == XMAX) begin
          state_d = ST_L_ISSUE;
        end else begin
          x_d     = mid_q + X_ONE;
          issue_s = 1'b1;
          wait_d  = LAT_M1;
          state_d = ST_R_WAIT;
        end
      end
      ST_R_WAIT, ST_L_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = (state_q == ST_R_WAIT) ? ST_R_CHECK : ST_L_CHECK;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_R_CHECK: begin
        if (dark_s) begin
          right_d = ((x_q - X_ONE) > right_q) ? (x_q - X_ONE) : right_q;
          state_d = ST_L_ISSUE;
        end else if (x_q == XMAX) begin
          right_d = XMAX;
          state_d = ST_L_ISSUE;
        end else begin
          x_d     = x_q + X_ONE;
          issue_s = 1'b1;
          wait_d  = LAT_M1;
          state_d = ST_R_WAIT;
        end
      end
      ST_L_ISSUE: begin
        if (mid_q == X_ZERO) begin
          state_d = ST_NEXT_ROW;
        end else begin
          x_d     = mid_q - X_ONE;
          issue_s = 1'b1;
          wait_d  = LAT_M1;
          state_d = ST_L_WAIT;
        end
      end
      ST_L_CHECK: begin
        if (dark_s) begin
          left_d  = ((x_q + X_ONE) < left_q) ? (x_q + X_ONE) : left_q;
          state_d = ST_NEXT_ROW;
        end else if (x_q == X_ZERO) begin
          left_d  = X_ZERO;
          state_d = ST_NEXT_ROW;
        end else begin
          x_d     = x_q - X_ONE;
          issue_s = 1'b1;
          wait_d  = LAT_M1;
          state_d = ST_L_WAIT;
        end
      end
      ST_NEXT_ROW: begin
        // stop early once the shape already spans the full width
        if ((y_q == bot_q) || ((left_q == X_ZERO) && (right_q == XMAX))) begin
          state_d = ST_FINISH;
        end else begin
          y_d     = y_q + Y_ONE;
          state_d = ST_R_ISSUE;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef MAP_COLUMNS_SCAN_ABORT_EN
    if (abort && busy_q) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      bad_d   = 1'b1;
    end else begin
      bad_d = bad_d;
    end
`endif
    mem_addr_d = issue_s ? addr_s : mem_addr_q;
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      top_q      <= '0;
      bot_q      <= '0;
      mid_q      <= '0;
      wait_q     <= 2'd0;
      left_q     <= '0;
      right_q    <= '0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      mid_q      <= mid_d;
      wait_q     <= wait_d;
      left_q     <= left_d;
      right_q    <= right_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mostLeft  = left_q;
  assign mostRight = right_q;
  assign bad_range = bad_q;

endmodule
